// File: rtl/lo_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// lo_sweep_ctrl
//
// Steps the low-frequency read datapath through a range of carrier divisors.
// For each divisor it discards a number of carrier periods so the antenna can
// settle. It then records the minimum and maximum ADC sample over a number of
// carrier periods and reports the peak-to-peak amplitude. The divisor with the
// largest amplitude is tracked. Ties keep the earlier (lower) divisor.
//
// Ports
//   pck0        in   24 MHz clock, all logic on the rising edge
//   nreset      in   asynchronous active-low reset
//   start       in   one-cycle pulse, begins a sweep when idle
//   abort       in   one-cycle pulse, ends a running sweep at once
//   div_min     in   first divisor                  (sampled on start)
//   div_max     in   last divisor, inclusive        (sampled on start)
//   settle      in   carrier periods discarded per step (sampled on start)
//   nsamp       in   carrier periods measured per step, 0 acts as 1
//   ant_lo      in   carrier from the datapath
//   adc_d       in   ADC sample bus
//   divisor     out  divisor driven to the datapath
//   busy        out  sweep in progress
//   step_valid  out  one-cycle pulse per completed step
//   step_div    out  divisor of the reported step
//   step_amp    out  peak-to-peak amplitude of the reported step
//   best_div    out  divisor with the largest amplitude so far
//   best_amp    out  largest amplitude so far
//   done        out  one-cycle pulse at sweep end (normal, error or abort)
//   err         out  sticky timeout / bad-range flag, cleared by next start
// ---------------------------------------------------------------------------
module lo_sweep_ctrl #(
    parameter int         TIMEOUT   = 1023,
    parameter logic [7:0] RESET_DIV = 8'd95
) (
    input  logic       pck0,
    input  logic       nreset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] div_min,
    input  logic [7:0] div_max,
    input  logic [7:0] settle,
    input  logic [7:0] nsamp,
    input  logic       ant_lo,
    input  logic [7:0] adc_d,
    output logic [7:0] divisor,
    output logic       busy,
    output logic       step_valid,
    output logic [7:0] step_div,
    output logic [7:0] step_amp,
    output logic [7:0] best_div,
    output logic [7:0] best_amp,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_REPORT,
        S_DONE
    } state_e;

    localparam int               TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic             ant_lo_q;
    logic [7:0]       div_max_q, div_max_d;
    logic [7:0]       settle_q, settle_d;
    logic [7:0]       nsamp_q, nsamp_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       min_q, min_d;
    logic [7:0]       max_q, max_d;
    logic [7:0]       divisor_q, divisor_d;
    logic             busy_q, busy_d;
    logic             step_valid_q, step_valid_d;
    logic [7:0]       step_div_q, step_div_d;
    logic [7:0]       step_amp_q, step_amp_d;
    logic [7:0]       best_div_q, best_div_d;
    logic [7:0]       best_amp_q, best_amp_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic       sample_evt;
    logic [7:0] amp_w;

    // Falling carrier edge seen through one register stage; adc_d is taken
    // in this same cycle.
    assign sample_evt = ant_lo_q & ~ant_lo;
    // At least one sample has been taken before REPORT, so max >= min.
    assign amp_w      = max_q - min_q;

    // NOTE: every variable gets its default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        div_max_d    = div_max_q;
        settle_d     = settle_q;
        nsamp_d      = nsamp_q;
        cnt_d        = cnt_q;
        min_d        = min_q;
        max_d        = max_q;
        divisor_d    = divisor_q;
        step_valid_d = 1'b0;
        step_div_d   = step_div_q;
        step_amp_d   = step_amp_q;
        best_div_d   = best_div_q;
        best_amp_d   = best_amp_q;
        done_d       = 1'b0;
        err_d        = err_q;

        // Carrier watchdog: reloads on every sample event, saturates at the
        // limit, and is held clear while idle.
        if (sample_evt) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_LIMIT) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = tmo_q;
        end

        if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            // Abort beats any sample event or report in the same cycle.
            state_d = S_DONE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    tmo_d = '0;
                    if (start && !abort) begin
                        div_max_d  = div_max;
                        settle_d   = settle;
                        nsamp_d    = (nsamp == 8'd0) ? 8'd1 : nsamp;
                        cnt_d      = 8'd0;
                        err_d      = 1'b0;
                        best_amp_d = 8'd0;
                        best_div_d = div_min;
                        divisor_d  = div_min;
                        if (div_min > div_max) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_SETTLE;
                        end
                    end
                end

                S_SETTLE: begin
                    min_d = 8'hFF;
                    max_d = 8'h00;
                    if (settle_q == 8'd0) begin
                        cnt_d   = 8'd0;
                        state_d = S_MEASURE;
                    end else if (sample_evt) begin
                        if (cnt_q == settle_q - 8'd1) begin
                            cnt_d   = 8'd0;
                            state_d = S_MEASURE;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else if (tmo_q == TMO_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end

                S_MEASURE: begin
                    if (sample_evt) begin
                        if (adc_d < min_q) min_d = adc_d;
                        if (adc_d > max_q) max_d = adc_d;
                        if (cnt_q == nsamp_q - 8'd1) begin
                            cnt_d   = 8'd0;
                            state_d = S_REPORT;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else if (tmo_q == TMO_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end

                S_REPORT: begin
                    step_valid_d = 1'b1;
                    step_div_d   = divisor_q;
                    step_amp_d   = amp_w;
                    if (amp_w > best_amp_q) begin
                        best_amp_d = amp_w;
                        best_div_d = divisor_q;
                    end
                    if (divisor_q == div_max_q) begin
                        state_d = S_DONE;
                    end else begin
                        divisor_d = divisor_q + 8'd1;
                        state_d   = S_SETTLE;
                    end
                end

                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end

                default: state_d = S_IDLE;
            endcase
        end

        // busy rises with the first non-idle state and falls together with
        // the done pulse.
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_IDLE;
            ant_lo_q     <= 1'b0;
            div_max_q    <= 8'd0;
            settle_q     <= 8'd0;
            nsamp_q      <= 8'd1;
            cnt_q        <= 8'd0;
            tmo_q        <= '0;
            min_q        <= 8'hFF;
            max_q        <= 8'h00;
            divisor_q    <= RESET_DIV;
            busy_q       <= 1'b0;
            step_valid_q <= 1'b0;
            step_div_q   <= 8'd0;
            step_amp_q   <= 8'd0;
            best_div_q   <= 8'd0;
            best_amp_q   <= 8'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ant_lo_q     <= ant_lo;
            div_max_q    <= div_max_d;
            settle_q     <= settle_d;
            nsamp_q      <= nsamp_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            min_q        <= min_d;
            max_q        <= max_d;
            divisor_q    <= divisor_d;
            busy_q       <= busy_d;
            step_valid_q <= step_valid_d;
            step_div_q   <= step_div_d;
            step_amp_q   <= step_amp_d;
            best_div_q   <= best_div_d;
            best_amp_q   <= best_amp_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign divisor    = divisor_q;
    assign busy       = busy_q;
    assign step_valid = step_valid_q;
    assign step_div   = step_div_q;
    assign step_amp   = step_amp_q;
    assign best_div   = best_div_q;
    assign best_amp   = best_amp_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
